proc_cmd_rx: RTL and testbench
==============================

PROC_CMD_RX -- requirements
Module: proc_cmd_rx

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, width of one command beat.
REQ-002 SHALL have parameter ADDR_W, default 16, operand/destination address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, inter-beat idle limit in cycles (used only with RX_TIMEOUT_EN).
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_en  input  1  this processor selected by issuer.
REQ-007 SHALL have port i_valid  input  1  issuer drives a valid beat on i_instr.
REQ-008 SHALL have port i_instr  input  INSTR_W  command beat.
REQ-009 SHALL have port i_exec_done  input  1  datapath completion pulse.
REQ-010 SHALL have port o_ack  output  1  beat-accepted pulse to issuer.
REQ-011 SHALL have port o_busy  output  1  transaction/execution in progress.
REQ-012 SHALL have port o_finish  output  1  one-cycle completion pulse.
REQ-013 SHALL have port o_start  output  1  one-cycle datapath launch pulse.
REQ-014 SHALL have ports o_ld1_addr, o_ld2_addr, o_dst_addr  output  ADDR_W each  captured addresses.
REQ-015 SHALL have ports o_op  output  4, o_len  output  16  captured operation and length.
REQ-016 SHALL have port o_err  output  1  timeout-abort pulse.

Function
REQ-017 SHALL implement states IDLE, RX, ACK, EXEC, DONE plus a 2-bit beat counter (0=LD1, 1=LD2, 2=INFO, 3=WRITE).
REQ-018 SHALL accept a beat in IDLE or RX only when i_en && i_valid are both 1 at a rising edge.
REQ-019 SHALL capture on accept: beat 0 -> o_ld1_addr=i_instr[ADDR_W-1:0]; beat 1 -> o_ld2_addr; beat 2 -> o_op=i_instr[3:0], o_len=i_instr[19:4]; beat 3 -> o_dst_addr.
REQ-020 SHALL move to ACK on every accept, drive o_ack=1 for exactly the one ACK cycle (ack appears the cycle after acceptance), and ignore i_valid while in ACK.
REQ-021 SHALL leave ACK to RX with counter+1 for beats 0-2; after beat 3 to EXEC with o_start=1 for that first EXEC cycle if o_len!=0, else directly to DONE with no o_start.
REQ-022 SHALL stay in EXEC until i_exec_done=1, then go to DONE; i_exec_done outside EXEC SHALL be ignored.
REQ-023 SHALL drive o_finish=1 for the single DONE cycle, then return to IDLE with counter=0.
REQ-024 SHALL assert o_busy from the cycle after beat 0 is accepted through the DONE cycle inclusive; 0 in IDLE.
REQ-025 SHALL hold in RX indefinitely while i_en or i_valid is low (without RX_TIMEOUT_EN).
REQ-026 SHALL keep captured fields stable from capture until overwritten by the next transaction's same beat.

Reset
REQ-027 SHALL on i_rstn=0, at any time including mid-transaction, force state=IDLE, counter=0, all outputs and captured fields to 0.
REQ-028 SHALL accept the first beat no earlier than the first rising edge after i_rstn deasserts.

Configuration
REQ-029 SHALL, with macro RX_TIMEOUT_EN defined, count consecutive RX cycles without an accept (counter reset on every accept) and on reaching TIMEOUT pulse o_err=1 for one cycle, return to IDLE, counter=0, o_busy=0.
REQ-030 SHALL, without RX_TIMEOUT_EN, include no timeout counter and tie o_err to 0.

Verification
REQ-031 SHALL test: four back-to-back beats 0x0010,0x0020,0x0000_0051 (op=1,len=5),0x0030 -> four o_ack pulses, o_start once, fields 0x10/0x20/1/5/0x30, i_exec_done -> o_finish one cycle later.
REQ-032 SHALL test: INFO beat 0x0000_0002 (len=0) -> no o_start, o_finish the cycle after beat-3 ACK.
REQ-033 SHALL test: i_valid held high through ACK -> exactly one capture per beat, no duplicate ack.
REQ-034 SHALL test: i_rstn pulsed low after beat 2 -> all outputs 0, next beat captured as LD1.
REQ-035 SHALL test: with RX_TIMEOUT_EN, stall 15 cycles after beat 1 -> o_err pulse, o_busy=0, IDLE; without macro -> waits, o_err stays 0.

Source files
------------

// File: rtl/proc_cmd_rx.sv
// Four-beat command receiver: LD1, LD2, INFO, WRITE beats are handshaked one at a time,
// then the datapath is launched and its completion reported. Optional RX_TIMEOUT_EN adds an RX idle abort.
module proc_cmd_rx #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic              i_exec_done,
    output logic              o_ack,
    output logic              o_busy,
    output logic              o_finish,
    output logic              o_start,
    output logic [ADDR_W-1:0] o_ld1_addr,
    output logic [ADDR_W-1:0] o_ld2_addr,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic [3:0]        o_op,
    output logic [15:0]       o_len,
    output logic              o_err
);

    typedef enum logic [2:0] {IDLE, RX, ACK, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              start_q, start_d;
    logic [ADDR_W-1:0] ld1_q, ld2_q, dst_q;
    logic [3:0]        op_q;
    logic [15:0]       len_q;
    logic              accept;
    logic              tmo_expired;
    logic              unused_instr_hi;

    assign accept          = (state_q == IDLE || state_q == RX) && i_en && i_valid;
    assign unused_instr_hi = ^i_instr[INSTR_W-1:20];

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q;

    // Counts consecutive RX cycles with no accepted beat; fires on the TIMEOUT-th one.
    assign tmo_expired = (state_q == RX) && !accept && (tmo_q == TW'(TIMEOUT - 1));
    assign tmo_d       = (state_q == RX && !accept) ? tmo_q + 1'b1 : '0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_expired ? '0 : tmo_d;
            err_q <= tmo_expired;
        end
    end
    assign o_err = err_q;
`else
    assign tmo_expired = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        start_d = 1'b0;
        case (state_q)
            IDLE, RX: begin
                if (accept) begin
                    state_d = ACK;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                    beat_d  = 2'd0;
                end
            end
            ACK: begin
                if (beat_q != 2'd3) begin
                    beat_d  = beat_q + 2'd1;
                    state_d = RX;
                end else if (len_q != 16'd0) begin
                    state_d = EXEC;
                    start_d = 1'b1;
                end else begin
                    // Zero-length commands skip the datapath entirely.
                    state_d = DONE;
                end
            end
            EXEC: begin
                if (i_exec_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
            default: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            start_q <= start_d;
        end
    end

    // Fields hold until the same beat of a later command overwrites them.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ld1_q <= '0;
            ld2_q <= '0;
            dst_q <= '0;
            op_q  <= '0;
            len_q <= '0;
        end else if (accept) begin
            case (beat_q)
                2'd0: ld1_q <= i_instr[ADDR_W-1:0];
                2'd1: ld2_q <= i_instr[ADDR_W-1:0];
                2'd2: begin
                    op_q  <= i_instr[3:0];
                    len_q <= i_instr[19:4];
                end
                default: dst_q <= i_instr[ADDR_W-1:0];
            endcase
        end
    end

    assign o_ack      = (state_q == ACK);
    assign o_busy     = (state_q != IDLE);
    assign o_finish   = (state_q == DONE);
    assign o_start    = start_q;
    assign o_ld1_addr = ld1_q;
    assign o_ld2_addr = ld2_q;
    assign o_dst_addr = dst_q;
    assign o_op       = op_q;
    assign o_len      = len_q;

endmodule

// File: tb/tb_proc_cmd_rx.sv
// Bench for proc_cmd_rx: directed command scenarios plus randomized commands checked
// against a transaction-level model of expected fields, pulse counts and timing.
module tb_proc_cmd_rx;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic               i_clk = 1'b0, i_rstn = 1'b0, i_en = 1'b0, i_valid = 1'b0, i_exec_done = 1'b0;
    logic [INSTR_W-1:0] i_instr = '0;
    logic               o_ack, o_busy, o_finish, o_start, o_err;
    logic [ADDR_W-1:0]  o_ld1_addr, o_ld2_addr, o_dst_addr;
    logic [3:0]         o_op;
    logic [15:0]        o_len;

    proc_cmd_rx #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_valid(i_valid), .i_instr(i_instr),
        .i_exec_done(i_exec_done), .o_ack(o_ack), .o_busy(o_busy), .o_finish(o_finish),
        .o_start(o_start), .o_ld1_addr(o_ld1_addr), .o_ld2_addr(o_ld2_addr),
        .o_dst_addr(o_dst_addr), .o_op(o_op), .o_len(o_len), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_err = 0;
    int acks = 0, starts = 0, fins = 0;

    always @(negedge i_clk) begin
        if (o_ack)    acks++;
        if (o_start)  starts++;
        if (o_finish) fins++;
    end

    typedef struct {
        logic [ADDR_W-1:0] ld1, ld2, dst;
        logic [3:0]        op;
        logic [15:0]       len;
    } fields_t;
    fields_t m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_ld1"}, 64'(o_ld1_addr), 64'(m.ld1));
        chk({tag, "_ld2"}, 64'(o_ld2_addr), 64'(m.ld2));
        chk({tag, "_op"},  64'(o_op),       64'(m.op));
        chk({tag, "_len"}, 64'(o_len),      64'(m.len));
        chk({tag, "_dst"}, 64'(o_dst_addr), 64'(m.dst));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {o_ack, o_busy, o_finish, o_start, o_err}, 0);
        chk({tag, "_flds"}, {o_ld1_addr, o_ld2_addr, o_dst_addr, o_op, o_len}, 0);
    endtask

    // Present one beat; it must be acked the following cycle, and only once.
    task automatic send(input logic [31:0] d, input bit hold);
        i_en = 1'b1; i_valid = 1'b1; i_instr = d;
        tick();
        chk("ack_pulse", o_ack, 1);
        chk("busy_in_ack", o_busy, 1);
        if (!hold) i_valid = 1'b0;
        tick();
        chk("ack_once", o_ack, 0);
        i_valid = 1'b0;
    endtask

    // Idle cycles where no beat may be taken: valid low, or valid high with the block deselected.
    task automatic gap(input int g, input bit exp_busy);
        for (int k = 0; k < g; k++) begin
            if ($urandom_range(1) == 1) begin
                i_en = 1'b0; i_valid = 1'b1; i_instr = $urandom;
            end else begin
                i_en = 1'b1; i_valid = 1'b0;
            end
            i_exec_done = ($urandom_range(3) == 0);
            tick();
            chk("gap_no_ack", o_ack, 0);
            chk("gap_busy", o_busy, exp_busy);
        end
        i_en = 1'b1; i_valid = 1'b0; i_exec_done = 1'b0;
    endtask

    // Expected post-beat-3 behaviour derived from the captured length.
    task automatic finish_txn(input int dlat, input int a0, input int s0, input int f0);
        if (m.len != 0) begin
            chk("start_first_exec", o_start, 1);
            chk("no_finish_in_exec", o_finish, 0);
            for (int k = 0; k < dlat; k++) begin
                tick();
                chk("exec_wait", {o_start, o_finish, o_busy}, 3'b001);
            end
            i_exec_done = 1'b1;
            tick();
            i_exec_done = 1'b0;
            chk("finish_after_done", o_finish, 1);
        end else begin
            chk("len0_no_start", o_start, 0);
            chk("len0_finish", o_finish, 1);
        end
        chk("busy_in_done", o_busy, 1);
        tick();
        chk("finish_single", o_finish, 0);
        chk("idle_not_busy", o_busy, 0);
        chk_fields("txn");
        chk("ack_count", acks - a0, 4);
        chk("start_count", starts - s0, (m.len != 0) ? 1 : 0);
        chk("finish_count", fins - f0, 1);
    endtask

    task automatic run_txn(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] b3, input bit hold, input int maxgap, input int dlat);
        int a0, s0, f0;
        a0 = acks; s0 = starts; f0 = fins;
        gap($urandom_range(maxgap), 1'b0);
        send(b0, hold); m.ld1 = b0[ADDR_W-1:0];
        gap($urandom_range(maxgap), 1'b1);
        send(b1, hold); m.ld2 = b1[ADDR_W-1:0];
        gap($urandom_range(maxgap), 1'b1);
        send(b2, hold); m.op = b2[3:0]; m.len = b2[19:4];
        gap($urandom_range(maxgap), 1'b1);
        send(b3, hold); m.dst = b3[ADDR_W-1:0];
        finish_txn(dlat, a0, s0, f0);
    endtask

    initial begin
        int a0, s0, f0;
        m = '{default: '0};
        #3;
        chk_all_zero("reset_state");
        tick();
        i_rstn = 1'b1;
        tick();

        // Nominal command, back to back.
        run_txn(32'h0010, 32'h0020, 32'h0000_0051, 32'h0030, 1'b0, 0, 2);
        chk("dir_fields", {o_ld1_addr, o_ld2_addr, o_op, o_len, o_dst_addr}, {16'h10, 16'h20, 4'h1, 16'h5, 16'h30});

        // Zero length: finish straight after the WRITE ack.
        run_txn(32'h0011, 32'h0022, 32'h0000_0002, 32'h0033, 1'b0, 0, 0);
        chk("len0_op", o_op, 2);

        // Valid held through every ACK cycle.
        run_txn(32'h1234_0101, 32'h0202, 32'h0000_0073, 32'h0303, 1'b1, 0, 1);

        // Async reset after the INFO beat; then a fresh LD1 beat.
        send(32'h0A0A, 1'b0);
        send(32'h0B0B, 1'b0);
        send(32'h0000_0C34, 1'b0);
        #2 i_rstn = 1'b0;
        #1 chk_all_zero("midtxn_reset");
        m = '{default: '0};
        @(negedge i_clk);
        i_rstn = 1'b1;
        tick();
        chk("post_reset_idle", o_busy, 0);
        a0 = acks; s0 = starts; f0 = fins;
        send(32'h0D0D, 1'b0); m.ld1 = 16'h0D0D;
        chk("reset_ld1", o_ld1_addr, 16'h0D0D);
        chk("reset_ld2_clear", o_ld2_addr, 0);
        send(32'h0E0E, 1'b0); m.ld2 = 16'h0E0E;
        send(32'h0000_0021, 1'b0); m.op = 4'h1; m.len = 16'h2;
        send(32'h0F0F, 1'b0); m.dst = 16'h0F0F;
        finish_txn(0, a0, s0, f0);

        // Long stall after LD2.
        a0 = acks; s0 = starts; f0 = fins;
        send(32'h4444, 1'b0); m.ld1 = 16'h4444;
        send(32'h5555, 1'b0); m.ld2 = 16'h5555;
`ifdef RX_TIMEOUT_EN
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk("tmo_wait", {o_err, o_busy}, 2'b01);
        end
        tick();
        chk("tmo_err", o_err, 1);
        chk("tmo_idle", o_busy, 0);
        tick();
        chk("tmo_err_pulse", o_err, 0);
        chk("tmo_ack_count", acks - a0, 2);
        run_txn(32'h6666, 32'h7777, 32'h0000_0015, 32'h8888, 1'b0, 2, 1);
`else
        for (int k = 0; k < TIMEOUT + 5; k++) begin
            tick();
            chk("stall_wait", {o_err, o_busy, o_ack}, 3'b010);
        end
        send(32'h0000_0015, 1'b0); m.op = 4'h5; m.len = 16'h1;
        send(32'h8888, 1'b0); m.dst = 16'h8888;
        finish_txn(1, a0, s0, f0);
`endif

        // Randomized commands with random gaps, hold and exec latency.
        for (int t = 0; t < 20; t++) begin
            logic [31:0] info;
            info = $urandom;
            if ($urandom_range(3) == 0) info[19:4] = 16'h0;
            run_txn($urandom, $urandom, info, $urandom, 1'($urandom_range(1)), 4, $urandom_range(4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
